// File: rtl/flux_pkg.sv
// Shared helpers for the flux_fifo tagged-token channel buffer.
// Holds the width functions for the tag and per-queue counters. It also
// defines the macros that split a token into its tag (MSBs) and data (LSBs).
package flux_pkg;

    // Number of tag bits needed to name FLUX sub-queues.
    function automatic int tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    // Counter width able to hold 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`ifndef FLUX_TOKEN_MACROS
`define FLUX_TOKEN_MACROS
// Token layout: {tag, data}; dw = data width, tw = tag width.
`define FLUX_TAG(tok, dw, tw) tok[(dw)+(tw)-1:(dw)]
`define FLUX_DATA(tok, dw)    tok[(dw)-1:0]
`endif

// File: rtl/flux_fifo_if.sv
// Channel bundle between a producer/consumer pair and one flux_fifo.
//   din/write/full : producer write side (din = {tag, data})
//   dout/read/empty: consumer side, one read/empty bit per sub-queue
// master = the actors driving the channel, slave = the flux_fifo itself.
interface flux_fifo_if
    import flux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2
);
    localparam int TOK_W = DATA_WIDTH + tag_w(FLUX);

    logic [TOK_W-1:0] din;
    logic             write;
    logic             full;
    logic [TOK_W-1:0] dout;
    logic [FLUX-1:0]  read;
    logic [FLUX-1:0]  empty;

    modport master (output din, write, read, input full, dout, empty);
    modport slave  (input din, write, read, output full, dout, empty);
endinterface

// File: rtl/flux_queue.sv
// Single circular sub-queue with first-word fall-through head.
//   clk, rst     : clock, asynchronous active-high reset
//   push, pop    : requests; a push while full or a pop while empty is ignored
//   wdata, rdata : write payload / current head payload
//   count        : occupancy 0..DEPTH
//   empty, full  : occupancy flags derived from registered count
module flux_queue
    import flux_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = cnt_w(DEPTH),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push_s, do_pop_s;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    assign empty = (count_q == {CNT_W{1'b0}});
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap at DEPTH-1.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end
endmodule

// File: rtl/flux_fifo.sv
// Tagged-token channel buffer: steers {tag, data} tokens into FLUX
// independent sub-queues and presents them as FLUX logical channels.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : flux_fifo_if slave (din/write/full, dout/read/empty)
// full is conservative: any sub-queue full blocks every write, whatever its tag.
module flux_fifo
    import flux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int FLUX       = 2
) (
    input  logic        clk,
    input  logic        rst,
    flux_fifo_if.slave  bus
);
    localparam int TAG_W = tag_w(FLUX);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int TOK_W = DATA_WIDTH + TAG_W;

    logic [TAG_W-1:0]      wr_tag_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  write_ok_s;
    logic                  full_s;
    logic [FLUX-1:0]       q_empty_s, q_full_s, q_occ_s, req_s, pop_s;
    logic [DATA_WIDTH-1:0] q_rdata_s [FLUX];
    logic [CNT_W-1:0]      q_count_s [FLUX];
    logic [TAG_W-1:0]      pop_idx_s, occ_idx_s, sel_idx_s;
    logic                  pop_hit_s, occ_hit_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    assign wr_tag_s   = `FLUX_TAG(bus.din, DATA_WIDTH, TAG_W);
    assign wr_data_s  = `FLUX_DATA(bus.din, DATA_WIDTH);
    assign full_s     = |q_full_s;
    assign write_ok_s = bus.write & ~full_s;
    assign req_s      = bus.read & ~q_empty_s;
    assign bus.full   = full_s;
    assign bus.empty  = q_empty_s;

    // A tag >= FLUX matches no queue, so such a write is silently dropped.
    for (genvar gi = 0; gi < FLUX; gi++) begin : g_q
        assign q_occ_s[gi] = (q_count_s[gi] != {CNT_W{1'b0}});
        flux_queue #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_queue (
            .clk   (clk),
            .rst   (rst),
            .push  (write_ok_s && (wr_tag_s == TAG_W'(gi))),
            .pop   (pop_s[gi]),
            .wdata (wr_data_s),
            .rdata (q_rdata_s[gi]),
            .count (q_count_s[gi]),
            .empty (q_empty_s[gi]),
            .full  (q_full_s[gi])
        );
    end

    // Priority select: lowest requested non-empty queue pops; otherwise show
    // the lowest non-empty head. Descending scans let the lowest index win.
    always_comb begin
        pop_hit_s  = 1'b0;
        pop_idx_s  = {TAG_W{1'b0}};
        occ_hit_s  = 1'b0;
        occ_idx_s  = {TAG_W{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
        pop_s      = {FLUX{1'b0}};
        for (int i = FLUX - 1; i >= 0; i--) begin
            pop_hit_s = pop_hit_s | req_s[i];
            pop_idx_s = req_s[i] ? TAG_W'(i) : pop_idx_s;
            occ_hit_s = occ_hit_s | q_occ_s[i];
            occ_idx_s = q_occ_s[i] ? TAG_W'(i) : occ_idx_s;
        end
        sel_idx_s = pop_hit_s ? pop_idx_s : occ_idx_s;
        for (int i = 0; i < FLUX; i++) begin
            pop_s[i]   = pop_hit_s && (pop_idx_s == TAG_W'(i));
            sel_data_s = (sel_idx_s == TAG_W'(i)) ? q_rdata_s[i] : sel_data_s;
        end
    end

    assign bus.dout = (pop_hit_s | occ_hit_s) ? {sel_idx_s, sel_data_s} : {TOK_W{1'b0}};
endmodule

// File: tb/tb_flux_fifo.sv
// Scoreboard bench for flux_fifo: directed stimulus pushes the expected
// popped token; a negedge monitor compares dout whenever a pop is presented.
module tb_flux_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flux_fifo_if #(.DATA_WIDTH(8), .FLUX(2)) bus_a ();
    flux_fifo_if #(.DATA_WIDTH(8), .FLUX(2)) bus_b ();

    flux_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FLUX(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    flux_fifo #(.DATA_WIDTH(8), .DEPTH(3), .FLUX(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [8:0] qa [$];
    logic [8:0] qb [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit pops(input logic [1:0] rd, input logic [1:0] em);
        return |(rd & ~em);
    endfunction

    // Monitor: on every presented pop, the head must match the scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && pops(bus_a.read, bus_a.empty)) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_a: got %0h expected nothing (scoreboard empty)", bus_a.dout);
            end else begin
                e = qa.pop_front();
                chk("pop_a", {23'd0, bus_a.dout}, {23'd0, e});
            end
        end
        if (!rst && pops(bus_b.read, bus_b.empty)) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_b: got %0h expected nothing (scoreboard empty)", bus_b.dout);
            end else begin
                e = qb.pop_front();
                chk("pop_b", {23'd0, bus_b.dout}, {23'd0, e});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic tag, input logic [7:0] d);
        bus_a.din = {tag, d};
        bus_a.write = 1'b1;
        cyc();
        bus_a.write = 1'b0;
    endtask

    task automatic pop_a(input logic [1:0] mask, input logic [8:0] exp);
        bus_a.read = mask;
        qa.push_back(exp);
        cyc();
        bus_a.read = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.din = 9'd0; bus_a.write = 1'b0; bus_a.read = 2'b00;
        bus_b.din = 9'd0; bus_b.write = 1'b0; bus_b.read = 2'b00;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst_empty", {30'd0, bus_a.empty}, 32'h3);
        chk("rst_full", {31'd0, bus_a.full}, 32'h0);
        chk("rst_dout", {23'd0, bus_a.dout}, 32'h0);
        cyc();

        // Interleaved tags, FWFT head, priority fallback.
        wr_a(1'b0, 8'h11); wr_a(1'b1, 8'h22); wr_a(1'b0, 8'h33);
        @(negedge clk);
        chk("mix_empty", {30'd0, bus_a.empty}, 32'h0);
        chk("mix_dout", {23'd0, bus_a.dout}, 32'h011);
        cyc();
        pop_a(2'b01, 9'h011);
        @(negedge clk);
        chk("mix_dout2", {23'd0, bus_a.dout}, 32'h033);
        cyc();
        pop_a(2'b01, 9'h033);
        @(negedge clk);
        chk("mix_empty0", {31'd0, bus_a.empty[0]}, 32'h1);
        chk("mix_dout3", {23'd0, bus_a.dout}, 32'h122);
        cyc();
        pop_a(2'b10, 9'h122);

        // Fill queue 1; conservative full blocks a write to queue 0.
        wr_a(1'b1, 8'hA0); wr_a(1'b1, 8'hA1); wr_a(1'b1, 8'hA2); wr_a(1'b1, 8'hA3);
        @(negedge clk);
        chk("q1_full", {31'd0, bus_a.full}, 32'h1);
        cyc();
        wr_a(1'b0, 8'h55);
        @(negedge clk);
        chk("drop_empty0", {31'd0, bus_a.empty[0]}, 32'h1);
        cyc();
        pop_a(2'b10, 9'h1A0);
        @(negedge clk);
        chk("q1_unfull", {31'd0, bus_a.full}, 32'h0);
        chk("q1_head", {23'd0, bus_a.dout}, 32'h1A1);
        cyc();
        pop_a(2'b10, 9'h1A1); pop_a(2'b10, 9'h1A2); pop_a(2'b10, 9'h1A3);

        // Queue 0 full with simultaneous write and pop: write dropped.
        wr_a(1'b0, 8'hB0); wr_a(1'b0, 8'hB1); wr_a(1'b0, 8'hB2); wr_a(1'b0, 8'hB3);
        @(negedge clk);
        chk("q0_full", {31'd0, bus_a.full}, 32'h1);
        cyc();
        bus_a.din = {1'b0, 8'h77}; bus_a.write = 1'b1;
        pop_a(2'b01, 9'h0B0);
        bus_a.write = 1'b0;
        @(negedge clk);
        chk("wp_full_drop", {31'd0, bus_a.full}, 32'h0);
        cyc();
        wr_a(1'b0, 8'h77);
        @(negedge clk);
        chk("wp_refull", {31'd0, bus_a.full}, 32'h1);
        cyc();
        pop_a(2'b01, 9'h0B1); pop_a(2'b01, 9'h0B2); pop_a(2'b01, 9'h0B3); pop_a(2'b01, 9'h077);
        @(negedge clk);
        chk("wp_drained", {30'd0, bus_a.empty}, 32'h3);
        cyc();

        // Both read bits set: only queue 0 pops.
        wr_a(1'b0, 8'hC0); wr_a(1'b1, 8'hD0);
        pop_a(2'b11, 9'h0C0);
        @(negedge clk);
        chk("dual_empty", {30'd0, bus_a.empty}, 32'h1);
        chk("dual_dout", {23'd0, bus_a.dout}, 32'h1D0);
        cyc();
        pop_a(2'b10, 9'h1D0);

        // Asynchronous reset mid-traffic.
        wr_a(1'b0, 8'hE1); wr_a(1'b1, 8'hE2);
        rst = 1'b1;
        #1;
        chk("arst_empty", {30'd0, bus_a.empty}, 32'h3);
        chk("arst_full", {31'd0, bus_a.full}, 32'h0);
        chk("arst_dout", {23'd0, bus_a.dout}, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("post_rst_empty", {30'd0, bus_a.empty}, 32'h3);
        cyc();

        // DEPTH=3 instance: ten tokens through queue 1 across pointer wraps.
        for (int k = 0; k < 10; k++) begin
            bus_b.din = {1'b1, 8'(k)};
            bus_b.write = 1'b1;
            if (k > 0) begin
                bus_b.read = 2'b10;
                qb.push_back({1'b1, 8'(k - 1)});
            end
            cyc();
        end
        bus_b.write = 1'b0;
        bus_b.read = 2'b10;
        qb.push_back({1'b1, 8'd9});
        cyc();
        bus_b.read = 2'b00;
        @(negedge clk);
        chk("wrap_empty", {30'd0, bus_b.empty}, 32'h3);
        cyc();
        @(negedge clk);
        chk("sb_a_left", qa.size(), 32'd0);
        chk("sb_b_left", qb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/flux_fifo.md
Name: flux_fifo

Overview:
- Tagged-token channel buffer between one SDF actor's write interface and one input port of the next actor's read interface.
- Accepts tokens of {tag, data}, where tag is the flux index, and steers each into one of FLUX independent circular sub-queues.
- Each sub-queue is exposed as its own empty/read pair, so a consumer port sees FLUX logical channels over a single dout bus.
- One instance per consumer port; PORTS instances feed one actor.

Parameters:
- DATA_WIDTH, 8, payload bits per token.
- DEPTH, 4, entries per sub-queue (any value >= 2; power of two not required).
- FLUX, 2, number of sub-queues / tag values (>= 2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- din  in  DATA_WIDTH+$clog2(FLUX)  write token; MSBs = tag, LSBs = data.
- write  in  1  write strobe from producer.
- full  out  1  high when any sub-queue holds DEPTH entries.
- dout  out  DATA_WIDTH+$clog2(FLUX)  head token of the selected sub-queue; MSBs = its index.
- read  in  FLUX  per-sub-queue pop request.
- empty  out  FLUX  per-sub-queue empty flag.

Behaviour:
- Reset (async assert, sync release):
  - All pointers and counts are 0.
  - empty = all ones; full = 0; dout = 0.
  - Storage contents are don't-care.
- Write:
  - Accepted when write=1 and full=0.
  - Data goes to sub-queue din[tag] at that queue's write pointer.
  - Write pointer advances and wraps DEPTH-1 -> 0; count increments.
  - Write while full=1 is dropped; no state changes.
  - Tag >= FLUX (non-power-of-two FLUX) is dropped.
- full rule:
  - Conservative: OR of all per-queue (count==DEPTH). It does not depend on din's tag.
  - Registered-state derived; no combinational path from din or write.
- Read select:
  - sel = lowest index i with read[i]=1 and empty[i]=0.
  - If none: lowest index non-empty queue.
  - If all empty: dout = 0.
  - dout = {sel, head data of sel}. This is first-word fall-through: valid in the same cycle empty[sel] is low.
- Pop:
  - Only the queue given by the first rule of sel pops.
  - Extra read bits on other queues are ignored this cycle. The consumer must re-assert them.
  - read[i] with empty[i]=1 is ignored.
  - Read pointer wraps DEPTH-1 -> 0; count decrements.
- Simultaneous write and pop:
  - Same queue, not full: both happen; count unchanged; ordering preserved.
  - Same queue, full: the pop happens and the write is dropped (full was high). No bypass.
  - Different queues: independent.
  - Write into an empty queue: visible on dout/empty the next cycle; no write-to-read bypass.
- Latency: write to empty-deassert is 1 cycle; pop to next head on dout is 1 cycle.
- Count width: $clog2(DEPTH+1). Pointer width: $clog2(DEPTH).
- Reset mid-operation: immediately returns to the reset state; tokens in flight are lost.

Decomposition:
- Package flux_pkg:
  - function tag_w(FLUX) = $clog2(FLUX).
  - function cnt_w(DEPTH) = $clog2(DEPTH+1).
  - token_t-style helper macros for splitting tag and data.
- Sub-module flux_queue: single circular queue with params DATA_WIDTH and DEPTH.
  - Ports: clk, rst, push, pop, wdata, rdata, count, empty, full.
  - Instantiated FLUX times in a generate loop.
- Top-level holds tag decode, the full OR-reduction, the sel priority mux and the pop arbitration.

Test Plan:
- Reset then idle → empty=2'b11, full=0, dout=0. Assert rst mid-traffic → same values asynchronously, before the next clock edge.
- Write {tag0,0x11},{tag1,0x22},{tag0,0x33} on consecutive cycles → empty=2'b00. With read=0, dout={0,0x11}. Pulse read=2'b01 → dout={0,0x33}. Pulse read=2'b01 → empty[0]=1 and dout={1,0x22}.
- Fill queue 1 with 4 writes (0xA0..0xA3) → full=1. A 5th write {tag0,0x55} is dropped and empty[0] stays 1. Read queue 1 once → full=0 next cycle; head = 0xA1.
- Queue 0 full, same cycle write {tag0,0x77} and read=2'b01 → write dropped, count=3. Then a write succeeds and 0x77 is read last, after the original 3 entries.
- read=2'b11 with both queues non-empty → only queue 0 pops; queue 1 count unchanged.
- 10 write/read pairs on queue 1 with DEPTH=3 (wrap) → data returned in order, 0x00..0x09, no loss or duplication.
